// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame: start(0), [parity], d[7]..d[0] (MSB first), stop(1).
// Optional feature macro: UART_RX_PARITY_EN. When it is defined the receiver
// expects an even parity bit right after the start bit and reports mismatches
// on parity_err. When it is undefined the frame has no parity bit and
// parity_err is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | line idle, waiting for a low sample on a baud tick
// START     | timing to the middle of the start bit to confirm it
// PARITY    | waiting for the parity-bit midpoint (parity builds only)
// DATA      | shifting in d[7]..d[0] at each bit midpoint
// STOP      | sampling the stop bit and publishing the frame
// WAIT_HIGH | stop bit was low; wait for the line to return high

module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST    = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        PARITY,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t         state;
    logic [TW-1:0]  tick_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     sh;
    logic           rx_meta;
    logic           rx_s;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
`else
    assign parity_err = 1'b0;
`endif

    // Frame FSM; all progress is gated by baud_tick, valid is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            tick_cnt <= '0;
                            state    <= START;
                            busy     <= 1'b1;
                        end
                    end

                    START: begin
                        if (tick_cnt == HALF_M1) begin
                            if (!rx_s) begin
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
                                state    <= PARITY;
`else
                                state    <= DATA;
`endif
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == LAST) begin
                            par_bit <= rx_s;
                            bit_cnt <= '0;
                            state   <= DATA;
                        end
                    end
`endif

                    DATA: begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == LAST) begin
                            sh      <= {sh[6:0], rx_s};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) begin
                                state <= STOP;
                            end
                        end
                    end

                    STOP: begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == LAST) begin
                            data_out  <= sh;
                            frame_err <= ~rx_s;
                            valid     <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= (par_bit != ^sh);
`endif
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= WAIT_HIGH;
                            end
                        end
                    end

                    WAIT_HIGH: begin
                        // A stuck-low or break line must not look like a new start bit.
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected frames, a monitor
// pops and compares on every valid pulse.
module tb_uart_rx;

    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int FRAME_TICKS = 176;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int FRAME_TICKS = 160;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Baud tick every 4 clk, changed on the falling edge; tick_count timestamps.
    int unsigned div = 0;
    int unsigned tick_count = 0;
    always @(negedge clk) begin
        if (baud_tick) tick_count = tick_count + 1;
        div = (div + 1) % 4;
        baud_tick = (div == 0);
    end

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned vtime_q[$];
    int          tests = 0;
    int          fails = 0;
    logic        prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each valid pulse against the head of the scoreboard.
    always @(negedge clk) begin
        if (valid) begin
            exp_t e;
            vtime_q.push_back(tick_count);
            check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got data 0x%0h expected no frame", data_out);
            end else begin
                e = exp_q.pop_front();
                check("data_out", {24'd0, data_out}, {24'd0, e.data});
                check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
                check("frame_err", {31'd0, frame_err}, {31'd0, e.ferr});
            end
        end
        prev_valid <= valid;
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        if (PAR_EN) send_bit(par);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr);
        exp_t e;
        e.data = d;
        e.perr = perr;
        e.ferr = ferr;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"}, {24'd0, data_out}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_ticks(10);

        // 0xA5, correct parity, good stop
        expect_frame(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_ticks(10);

        // 0x3C with parity bit 1 (mismatch when parity is enabled)
        expect_frame(8'h3C, PAR_EN, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_ticks(10);

        // 0x81 with low stop bit, line held low, then released
        expect_frame(8'h81, 1'b0, 1'b1);
        send_frame(8'h81, 1'b0, 1'b0);
        wait_ticks(40);
        check("busy_wait_high", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        wait_ticks(3);
        check("busy_after_release", {31'd0, busy}, 32'd0);
        wait_ticks(10);

        // 4-tick low glitch: START only, no frame
        rx = 1'b0;
        wait_ticks(3);
        check("busy_glitch_start", {31'd0, busy}, 32'd1);
        wait_ticks(1);
        rx = 1'b1;
        wait_ticks(12);
        check("busy_glitch_idle", {31'd0, busy}, 32'd0);
        wait_ticks(10);

        // Back-to-back 0x55, 0xAA with a single stop bit
        vtime_q.delete();
        expect_frame(8'h55, 1'b0, 1'b0);
        expect_frame(8'hAA, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1);
        send_frame(8'hAA, 1'b0, 1'b1);
        wait_ticks(10);
        check("b2b_valid_count", vtime_q.size(), 32'd2);
        if (vtime_q.size() == 2)
            check("b2b_spacing_ticks", vtime_q[1] - vtime_q[0], FRAME_TICKS);

        // Reset during DATA of 0xFF, then clean 0x12
        send_bit(1'b0);
        if (PAR_EN) send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midframe_reset");
        rx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        rst = 1'b0;
        wait_ticks(20);
        expect_frame(8'h12, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b1);
        wait_ticks(20);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART subsystem. Sits directly downstream of the UART transmit line and recovers bytes from the asynchronous `rx` input using an oversampling tick from the shared baud generator. Each completed frame is delivered as a one-cycle `valid` pulse with the byte and its error flags, for the receive buffer or host logic.

## Interface

- `OVERSAMPLE`, 16, ticks per bit period; power of two, 8 or 16 legal.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `baud_tick`  in  1  one-`clk` enable pulse at `OVERSAMPLE` × baud rate.
- `rx`  in  1  asynchronous serial line; idle high.
- `data_out`  out  8  last received byte; held until the next frame completes.
- `valid`  out  1  one-`clk` pulse when `data_out` and the error flags update.
- `parity_err`  out  1  parity mismatch on the last frame; held with `data_out`.
- `frame_err`  out  1  stop bit sampled low on the last frame; held with `data_out`.
- `busy`  out  1  high in every state except IDLE.

## Operation

- Frame format: start (0), parity, d[7], d[6], …, d[0], stop (1). Data is MSB first, matching the team transmitter. Parity is even: parity bit = ^d.
- `rx` passes through a 2-flop synchronizer to give `rx_s`. All decisions use `rx_s`.
- Counters:
  - `tick_cnt`, width log2(`OVERSAMPLE`), wraps naturally.
  - `bit_cnt`, 3 bits.
  - Shift register: `sh <= {sh[6:0], rx_s}`.
- States:
  - IDLE: on `baud_tick` with `rx_s`=0, clear `tick_cnt` and go to START.
  - START: count ticks. At `tick_cnt` = `OVERSAMPLE`/2−1, sample `rx_s`:
    - 0: clear `tick_cnt` and go to PARITY.
    - 1: false start; return to IDLE with no outputs.
  - PARITY: count ticks. At `tick_cnt` = `OVERSAMPLE`−1, capture the parity bit and go to DATA with `bit_cnt`=0.
  - DATA: at each `tick_cnt` = `OVERSAMPLE`−1, shift `rx_s` into `sh` and increment `bit_cnt`. After the sample taken at `bit_cnt`=7, go to STOP.
  - STOP: at `tick_cnt` = `OVERSAMPLE`−1, sample the stop bit, then:
    - Load `data_out` with `sh`.
    - Set `parity_err` = (captured parity ≠ ^`sh`).
    - Set `frame_err` = ~`rx_s`.
    - Pulse `valid`.
    - Go to IDLE if `rx_s`=1, else go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a stuck-low or break line from retriggering.
- Every sample point lands mid-bit. Returning to IDLE at the stop-bit midpoint allows back-to-back frames with a single stop bit.
- Ticks arriving outside the states above are ignored. `clk` cycles without `baud_tick` leave all state unchanged.

## Timing

- Reset values:
  - State IDLE; counters and `sh` 0; synchronizer flops 1.
  - `data_out`=0x00; `valid`, `parity_err`, `frame_err`, `busy` = 0.
- `rx` to `rx_s` latency: 2 `clk`.
- `valid` asserts exactly one `clk` after the `clk` edge where the stop-bit tick is registered. `data_out` and the flags change on that same edge.
- `valid` is never high for two consecutive cycles.
- The flags are not sticky across frames: each `valid` overwrites both.
- `busy` rises the cycle after start detection. It falls together with `valid` when the stop bit is high; otherwise it falls on exit from WAIT_HIGH.
- `rst` mid-frame returns to IDLE immediately. No `valid` is produced for the aborted frame.

## Configuration

- `UART_RX_PARITY_EN` defined:
  - The PARITY state exists and the frame is 11 bits.
  - `parity_err` behaves as specified above.
- Not defined:
  - PARITY is removed: START goes directly to DATA, and the frame is start, d[7..0], stop (10 bits).
  - `parity_err` is tied to 0.

## Test plan

- Byte 0xA5 (parity 0) at `OVERSAMPLE`=16 -> one `valid` pulse; `data_out`=0xA5, `parity_err`=0, `frame_err`=0.
- Byte 0x3C sent with parity bit 1 (`UART_RX_PARITY_EN`) -> `data_out`=0x3C, `parity_err`=1.
- Byte 0x81 with stop bit 0, then line held low for 40 ticks, then released -> `data_out`=0x81, `frame_err`=1; `busy` stays high until `rx_s` returns to 1; no second `valid`.
- Low glitch of 4 ticks on an idle line -> no `valid`; state returns to IDLE; `busy` pulses only during START.
- Frames 0x55 then 0xAA back-to-back with one stop bit -> two `valid` pulses 176 ticks apart (160 without parity); data correct.
- `rst` asserted during DATA of 0xFF, then a clean 0x12 frame -> only one `valid`, with `data_out`=0x12; all outputs at reset values while `rst` is high.
